// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the multi-channel servo PWM block: register map
// and the pulse-width clamp applied to TARGET writes.
package servo_pwm_pkg;

  localparam logic [4:0] ADDR_CTRL         = 5'd0;
  localparam logic [4:0] ADDR_STATUS       = 5'd1;
  localparam logic [4:0] ADDR_SLEW         = 5'd2;
  localparam logic [4:0] ADDR_TARGET_BASE  = 5'd8;
  localparam logic [4:0] ADDR_CURRENT_BASE = 5'd16;

  function automatic logic [63:0] clamp_ticks(input logic [63:0] val,
                                              input logic [63:0] lo,
                                              input logic [63:0] hi);
    logic [63:0] res;
    res = val;
    if (val < lo) res = lo;
    else if (val > hi) res = hi;
    return res;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: target/current width registers, per-frame slew step,
// and the registered compare against the shared frame counter.
module servo_channel
  import servo_pwm_pkg::*;
#(
  parameter int CNT_W  = 20,
  parameter int CENTER = 75000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic             i_wrap,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_slew,
  input  logic             i_wr_target,
  input  logic [CNT_W-1:0] i_target_wdata,
  output logic [CNT_W-1:0] o_target,
  output logic [CNT_W-1:0] o_cur,
  output logic             o_busy,
  output logic             o_servo
);

  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_cur;
  logic             r_servo;

  logic [CNT_W:0]   w_cur_x;
  logic [CNT_W:0]   w_tgt_x;
  logic [CNT_W:0]   w_slew_x;
  logic [CNT_W:0]   w_diff;
  logic             w_up;
  logic [CNT_W-1:0] w_next;

  // One extra bit keeps the difference and step free of wraparound.
  always_comb begin
    w_cur_x  = {1'b0, r_cur};
    w_tgt_x  = {1'b0, r_target};
    w_slew_x = {1'b0, i_slew};
    w_up     = (r_target > r_cur);
    w_diff   = w_up ? (w_tgt_x - w_cur_x) : (w_cur_x - w_tgt_x);
    w_next   = r_target;
    if ((i_slew != '0) && (w_diff > w_slew_x)) begin
      if (w_up) w_next = CNT_W'(w_cur_x + w_slew_x);
      else      w_next = CNT_W'(w_cur_x - w_slew_x);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_target <= CNT_W'(CENTER);
      r_cur    <= CNT_W'(CENTER);
      r_servo  <= 1'b0;
    end else begin
      if (i_wr_target) r_target <= i_target_wdata;
      if (i_wrap)      r_cur    <= w_next;
      // High for cnt = 0 .. cur-1, seen one cycle later: exactly cur cycles.
      r_servo <= i_en && (i_cnt < r_cur);
    end
  end

  assign o_target = r_target;
  assign o_cur    = r_cur;
  assign o_busy   = (r_cur != r_target);
  assign o_servo  = r_servo;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator on an Avalon-MM slave: shared frame
// counter, CTRL/SLEW registers, address decode and registered read mux.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int PERIOD_TICKS = 1000000,
  parameter int MIN_TICKS    = 50000,
  parameter int MAX_TICKS    = 100000,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  input  logic              avs_read,
  output logic [DATA_W-1:0] avs_readdata,
  output logic [NUM_CH-1:0] servo_out,
  output logic              frame_start
);

  localparam int CNT_W  = $clog2(PERIOD_TICKS);
  localparam int CENTER = (MIN_TICKS + MAX_TICKS) / 2;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_frame_start;
  logic [NUM_CH-1:0] r_ctrl;
  logic [NUM_CH-1:0] r_en_shadow;
  logic [CNT_W-1:0]  r_slew;
  logic [DATA_W-1:0] r_readdata;

  logic              w_wrap;
  logic              w_wr;
  logic              w_rd;
  logic [CNT_W-1:0]  w_tgt_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [CNT_W-1:0]  w_cur [NUM_CH];
  logic [CNT_W-1:0]  w_tgt [NUM_CH];
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_wr_tgt;

  // Bus handshake: chipselect qualifies avs_read/avs_write; there is no
  // waitrequest, a write lands on the next edge, readdata is registered and
  // valid the cycle after avs_read.
  assign w_wr        = avs_chipselect && avs_write;
  assign w_rd        = avs_chipselect && avs_read;
  assign w_wrap      = (r_cnt == CNT_W'(PERIOD_TICKS - 1));
  assign w_tgt_wdata = CNT_W'(clamp_ticks(64'(avs_writedata),
                                          64'(MIN_TICKS), 64'(MAX_TICKS)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      r_frame_start <= 1'b0;
      r_ctrl        <= '0;
      r_en_shadow   <= '0;
      r_slew        <= '0;
      r_readdata    <= '0;
    end else begin
      r_cnt         <= w_wrap ? '0 : r_cnt + 1'b1;
      r_frame_start <= w_wrap;
      if (w_wrap) r_en_shadow <= r_ctrl;
      if (w_wr && (avs_address == ADDR_CTRL)) r_ctrl <= NUM_CH'(avs_writedata);
      if (w_wr && (avs_address == ADDR_SLEW)) r_slew <= CNT_W'(avs_writedata);
      if (w_rd) r_readdata <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (avs_address == ADDR_CTRL)        w_rdata = DATA_W'(r_ctrl);
    else if (avs_address == ADDR_STATUS) w_rdata = DATA_W'(w_busy);
    else if (avs_address == ADDR_SLEW)   w_rdata = DATA_W'(r_slew);
    for (int i = 0; i < NUM_CH; i++) begin
      if (avs_address == 5'(ADDR_TARGET_BASE + i))  w_rdata = DATA_W'(w_tgt[i]);
      if (avs_address == 5'(ADDR_CURRENT_BASE + i)) w_rdata = DATA_W'(w_cur[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr_tgt[g] = w_wr && (avs_address == 5'(ADDR_TARGET_BASE + g));

    servo_channel #(
      .CNT_W  (CNT_W),
      .CENTER (CENTER)
    ) u_ch (
      .clk            (clk),
      .reset          (reset),
      .i_cnt          (r_cnt),
      .i_wrap         (w_wrap),
      .i_en           (r_en_shadow[g]),
      .i_slew         (r_slew),
      .i_wr_target    (w_wr_tgt[g]),
      .i_target_wdata (w_tgt_wdata),
      .o_target       (w_tgt[g]),
      .o_cur          (w_cur[g]),
      .o_busy         (w_busy[g]),
      .o_servo        (servo_out[g])
    );
  end

  assign avs_readdata = r_readdata;
  assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a 100-cycle frame, widths 10..20.
module tb_servo_pwm_multi;

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_STATUS = 5'd1;
  localparam logic [4:0] A_SLEW   = 5'd2;
  localparam logic [4:0] A_TGT0   = 5'd8;
  localparam logic [4:0] A_CUR0   = 5'd16;

  logic        clk;
  logic        reset;
  logic [4:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [3:0]  servo_out;
  logic        frame_start;

  int tests_run;
  int fail_cnt;

  servo_pwm_multi #(
    .NUM_CH       (4),
    .PERIOD_TICKS (100),
    .MIN_TICKS    (10),
    .MAX_TICKS    (20),
    .DATA_W       (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .servo_out      (servo_out),
    .frame_start    (frame_start)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic avs_wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Leaves the caller at the negedge of a frame's cnt==0 cycle.
  task automatic sync_frame(output bit ok);
    ok = 1'b0;
    @(posedge clk);
    for (int t = 0; t < 250; t++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      tests_run++; fail_cnt++;
      $display("FAIL frame_timeout: no frame_start within 250 cycles, required one");
    end
  endtask

  // Measures one whole frame for channel ch; reads STATUS mid-frame.
  task automatic measure_frame(input int ch, output int width, output int rise,
                               output logic [3:0] seen, output logic [31:0] status);
    bit ok;
    width = 0; rise = -1; seen = '0; status = '0;
    sync_frame(ok);
    if (!ok) return;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (servo_out[ch]) begin
        width++;
        if (rise < 0) rise = k;
      end
      seen = seen | servo_out;
      if (k == 50) begin avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = A_STATUS; end
      if (k == 51) begin avs_chipselect = 1'b0; avs_read = 1'b0; end
      if (k == 52) status = avs_readdata;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int hi;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (avs_readdata !== 32'd0) begin fail_cnt++; $display("FAIL reset_readdata: got %0d want 0", avs_readdata); end
    avs_rd(A_CTRL, d);
    tests_run++;
    if (d !== 32'd0) begin fail_cnt++; $display("FAIL reset_ctrl: got %0d want 0", d); end
    avs_rd(A_CUR0, d);
    tests_run++;
    if (d !== 32'd15) begin fail_cnt++; $display("FAIL reset_current0: got %0d want 15", d); end
    avs_rd(A_STATUS, d);
    tests_run++;
    if (d !== 32'd0) begin fail_cnt++; $display("FAIL reset_status: got %0d want 0", d); end
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (servo_out !== 4'b0000) hi++;
    end
    tests_run++;
    if (hi != 0) begin fail_cnt++; $display("FAIL reset_servo_low: %0d cycles nonzero want 0", hi); end
  endtask

  task automatic test_enable();
    int w, r;
    logic [3:0] seen;
    logic [31:0] st;
    avs_wr(A_TGT0, 32'd12);
    avs_wr(A_SLEW, 32'd0);
    avs_wr(A_CTRL, 32'd1);
    measure_frame(0, w, r, seen, st);
    tests_run++;
    if (w != 12) begin fail_cnt++; $display("FAIL enable_width: got %0d want 12", w); end
    tests_run++;
    if (r != 1) begin fail_cnt++; $display("FAIL enable_rise: got %0d want 1", r); end
    tests_run++;
    if (seen[3:1] !== 3'b000) begin fail_cnt++; $display("FAIL enable_others_low: got %b want 000", seen[3:1]); end
    measure_frame(0, w, r, seen, st);
    tests_run++;
    if (w != 12) begin fail_cnt++; $display("FAIL enable_width2: got %0d want 12", w); end
  endtask

  task automatic test_clamp();
    logic [31:0] d;
    avs_wr(A_TGT0 + 5'd1, 32'd5);
    avs_rd(A_TGT0 + 5'd1, d);
    tests_run++;
    if (d !== 32'd10) begin fail_cnt++; $display("FAIL clamp_low: got %0d want 10", d); end
    avs_wr(A_TGT0 + 5'd1, 32'd30);
    avs_rd(A_TGT0 + 5'd1, d);
    tests_run++;
    if (d !== 32'd20) begin fail_cnt++; $display("FAIL clamp_high: got %0d want 20", d); end
  endtask

  task automatic test_slew();
    int exp_w[4];
    logic exp_b[4];
    int w, r;
    logic [3:0] seen;
    logic [31:0] st;
    bit ok;
    exp_w = '{17, 19, 20, 20};
    exp_b = '{1'b1, 1'b1, 1'b0, 1'b0};
    sync_frame(ok);
    avs_wr(A_SLEW, 32'd2);
    avs_wr(A_TGT0 + 5'd2, 32'd20);
    avs_wr(A_CTRL, 32'd5);
    avs_rd(A_STATUS, st);
    tests_run++;
    if (st[2] !== 1'b1) begin fail_cnt++; $display("FAIL slew_status_pre: got %b want 1", st[2]); end
    for (int f = 0; f < 4; f++) begin
      measure_frame(2, w, r, seen, st);
      tests_run++;
      if (w != exp_w[f]) begin fail_cnt++; $display("FAIL slew_width[%0d]: got %0d want %0d", f, w, exp_w[f]); end
      tests_run++;
      if (st[2] !== exp_b[f]) begin fail_cnt++; $display("FAIL slew_status[%0d]: got %b want %b", f, st[2], exp_b[f]); end
    end
  endtask

  task automatic test_mid_frame();
    int w, r;
    logic [3:0] seen;
    logic [31:0] st;
    bit ok;
    sync_frame(ok);
    w = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (servo_out[0]) w++;
      if (k == 5) begin
        avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = A_TGT0; avs_writedata = 32'd18;
      end
      if (k == 6) begin avs_address = A_CTRL; avs_writedata = 32'd0; end
      if (k == 7) begin avs_chipselect = 1'b0; avs_write = 1'b0; end
    end
    tests_run++;
    if (w != 12) begin fail_cnt++; $display("FAIL midframe_width: got %0d want 12", w); end
    measure_frame(0, w, r, seen, st);
    tests_run++;
    if (w != 0) begin fail_cnt++; $display("FAIL midframe_next_low: got %0d want 0", w); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bit ok;
    avs_wr(A_CTRL, 32'd1);
    sync_frame(ok);
    repeat (3) @(negedge clk);
    tests_run++;
    if (servo_out[0] !== 1'b1) begin fail_cnt++; $display("FAIL async_pulse_high: got %b want 1", servo_out[0]); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (servo_out !== 4'b0000) begin fail_cnt++; $display("FAIL async_drop: got %b want 0000", servo_out); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    avs_rd(A_CUR0, d);
    tests_run++;
    if (d !== 32'd15) begin fail_cnt++; $display("FAIL async_current0: got %0d want 15", d); end
  endtask

  initial begin
    tests_run      = 0;
    fail_cnt       = 0;
    reset          = 1'b1;
    avs_address    = '0;
    avs_chipselect = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_read       = 1'b0;
    test_reset();
    test_enable();
    test_clamp();
    test_slew();
    test_mid_frame();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
